// File: rtl/tiny_riscv_load_store_unit_if.sv
// tiny_riscv_load_store_unit_if: CPU request/response and memory bus of the load/store unit
interface tiny_riscv_load_store_unit_if;
  logic        i_start;
  logic        i_is_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_store_data;
  logic [31:0] i_mem_data;
  logic        o_busy;
  logic        o_done;
  logic        o_fault;
  logic [31:0] o_load_data;
  logic [31:0] o_mem_addr;
  logic        o_read_strobe;
  logic [31:0] o_mem_write_data;
  logic [3:0]  o_mem_write_mask;
  modport slave (
    input  i_start, i_is_store, i_funct3, i_addr, i_store_data, i_mem_data,
    output o_busy, o_done, o_fault, o_load_data, o_mem_addr, o_read_strobe,
           o_mem_write_data, o_mem_write_mask
  );
  modport master (
    output i_start, i_is_store, i_funct3, i_addr, i_store_data, i_mem_data,
    input  o_busy, o_done, o_fault, o_load_data, o_mem_addr, o_read_strobe,
           o_mem_write_data, o_mem_write_mask
  );
endinterface

// File: rtl/tiny_riscv_load_store_unit.sv
// tiny_riscv_load_store_unit: byte/half/word load-store sequencer with alignment and range faults
module tiny_riscv_load_store_unit #(
  parameter int unsigned MEM_BYTES = 6144
) (
  input logic i_Clk,
  input logic i_Reset,
  tiny_riscv_load_store_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD_REQ, LOAD_WAIT, STORE, DONE} state_t;
  state_t state, state_nx;
  logic fault_q;
  logic [2:0] funct3_q;
  logic [31:0] addr_q, data_q, lane, load_fmt;
  logic [4:0] sh;
  logic bad;
  // Unsigned funct3 100/101 only exist as loads; everything else unlisted is illegal.
  assign bad = !(bus.i_funct3 inside {3'b000, 3'b001, 3'b010} ||
                 (!bus.i_is_store && bus.i_funct3 inside {3'b100, 3'b101})) ||
               (bus.i_funct3[1:0] == 2'b01 && bus.i_addr[0]) ||
               (bus.i_funct3 == 3'b010 && bus.i_addr[1:0] != 2'b00) ||
               bus.i_addr >= 32'(MEM_BYTES);
  assign sh = {addr_q[1:0], 3'b000};
  assign lane = bus.i_mem_data >> sh;
  assign load_fmt = funct3_q[1] ? lane :
                    funct3_q[0] ? {{16{~funct3_q[2] & lane[15]}}, lane[15:0]} :
                                  {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
  always_ff @(posedge i_Clk)
    if (i_Reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.i_start ? (bad ? DONE : bus.i_is_store ? STORE : LOAD_REQ) : IDLE) :
               state == LOAD_REQ ? LOAD_WAIT :
               state == DONE ? IDLE : DONE;
    bus.o_busy = state != IDLE;
    bus.o_done = state == DONE;
    bus.o_fault = state == DONE && fault_q;
    bus.o_read_strobe = state == LOAD_REQ;
    bus.o_mem_addr = (state == LOAD_REQ || state == STORE) ? {addr_q[31:2], 2'b00} : '0;
    bus.o_mem_write_mask = state != STORE ? 4'b0000 :
                           funct3_q[1] ? 4'b1111 :
                           (funct3_q[0] ? 4'b0011 : 4'b0001) << addr_q[1:0];
    bus.o_mem_write_data = state == STORE ? data_q << sh : '0;
  end
  always_ff @(posedge i_Clk)
    if (i_Reset) begin
      fault_q <= 1'b0;
      funct3_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      bus.o_load_data <= '0;
    end else begin
      if (state == IDLE && bus.i_start) begin
        fault_q <= bad;
        funct3_q <= bus.i_funct3;
        addr_q <= bus.i_addr;
        data_q <= bus.i_store_data;
      end
      if (state == LOAD_WAIT) bus.o_load_data <= load_fmt;
    end
endmodule

// File: tb/tb_tiny_riscv_load_store_unit.sv
// tb_tiny_riscv_load_store_unit: scoreboard bench against a byte-array model of memory
module tb_tiny_riscv_load_store_unit;
  localparam int MB = 6144;
  logic i_Clk = 0;
  logic i_Reset = 1;
  always #5 i_Clk = ~i_Clk;
  tiny_riscv_load_store_unit_if bus();
  tiny_riscv_load_store_unit #(.MEM_BYTES(MB)) dut (.i_Clk(i_Clk), .i_Reset(i_Reset), .bus(bus));

  typedef struct {bit fault; logic [31:0] data; int lat; int rd; int wr; int t0;} exp_t;
  exp_t q[$];
  logic [7:0] mem [MB];
  logic [7:0] ref_mem [MB];
  logic [31:0] last_load = 0;
  int cyc = 0, total = 0, passed = 0, rd_cnt = 0, wr_cnt = 0;

  always @(posedge i_Clk) cyc++;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] rd_word(logic [31:0] a);
    logic [31:0] w = 0;
    for (int n = 0; n < 4; n++) if (a + n < MB) w[8*n +: 8] = mem[a + n];
    return w;
  endfunction

  // Memory responder and scoreboard monitor, both away from the active edge.
  always @(negedge i_Clk) begin
    exp_t e;
    if (i_Reset) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (bus.o_read_strobe) begin
        rd_cnt++;
        bus.i_mem_data = rd_word(bus.o_mem_addr);
      end
      if (bus.o_mem_write_mask != 4'b0000) begin
        wr_cnt++;
        for (int n = 0; n < 4; n++)
          if (bus.o_mem_write_mask[n] && bus.o_mem_addr + n < MB)
            mem[bus.o_mem_addr + n] = bus.o_mem_write_data[8*n +: 8];
      end
      if (bus.o_done) begin
        if (q.size() == 0) chk("spurious_done", 32'(bus.o_done), 0);
        else begin
          e = q.pop_front();
          chk("fault", 32'(bus.o_fault), 32'(e.fault));
          chk("latency", cyc - e.t0, e.lat);
          chk("load_data", bus.o_load_data, e.data);
          chk("read_strobes", rd_cnt, e.rd);
          chk("write_cycles", wr_cnt, e.wr);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 20 && bus.o_busy; i++) begin
      @(posedge i_Clk);
      #1;
    end
    if (bus.o_busy) chk("idle_timeout", 32'(bus.o_busy), 0);
  endtask

  task automatic issue(bit st, logic [2:0] f3, logic [31:0] a, logic [31:0] d, int spur);
    exp_t e;
    int size;
    bit legal;
    logic [31:0] v;
    wait_idle();
    legal = (f3 inside {3'd0, 3'd1, 3'd2}) || (!st && f3 inside {3'd4, 3'd5});
    size = f3[1] ? 4 : f3[0] ? 2 : 1;
    e.fault = !legal || (a % size != 0) || a >= MB;
    e.rd = (!e.fault && !st) ? 1 : 0;
    e.wr = (!e.fault && st) ? 1 : 0;
    e.lat = e.fault ? 1 : st ? 2 : 3;
    if (!e.fault && st)
      for (int i = 0; i < size; i++) ref_mem[a + i] = d[8*i +: 8];
    if (!e.fault && !st) begin
      v = 0;
      for (int i = 0; i < size; i++) v |= 32'(ref_mem[a + i]) << (8 * i);
      if (!f3[2] && size == 1) v = {{24{v[7]}}, v[7:0]};
      if (!f3[2] && size == 2) v = {{16{v[15]}}, v[15:0]};
      last_load = v;
    end
    e.data = last_load;
    e.t0 = cyc;
    q.push_back(e);
    bus.i_start = 1;
    bus.i_is_store = st;
    bus.i_funct3 = f3;
    bus.i_addr = a;
    bus.i_store_data = d;
    @(posedge i_Clk);
    #1;
    // Extra start pulses while busy must be dropped, not queued.
    repeat (spur) begin
      if (!bus.o_busy) break;
      bus.i_start = 1;
      bus.i_is_store = 1'($urandom);
      bus.i_funct3 = 3'($urandom);
      bus.i_addr = $urandom_range(0, 127);
      bus.i_store_data = $urandom;
      @(posedge i_Clk);
      #1;
    end
    bus.i_start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int mode;
    logic [31:0] a;
    bus.i_start = 0;
    bus.i_is_store = 0;
    bus.i_funct3 = 0;
    bus.i_addr = 0;
    bus.i_store_data = 0;
    for (int i = 0; i < MB; i++) begin
      mem[i] = 8'($urandom);
      ref_mem[i] = mem[i];
    end
    {mem[259], mem[258], mem[257], mem[256]} = 32'h80FF_0102;
    {ref_mem[259], ref_mem[258], ref_mem[257], ref_mem[256]} = 32'h80FF_0102;
    repeat (2) @(posedge i_Clk);
    #1;
    i_Reset = 0;
    chk("rst_busy", 32'(bus.o_busy), 0);
    chk("rst_done", 32'(bus.o_done), 0);
    chk("rst_fault", 32'(bus.o_fault), 0);
    chk("rst_strobe", 32'(bus.o_read_strobe), 0);
    chk("rst_mask", 32'(bus.o_mem_write_mask), 0);
    chk("rst_load_data", bus.o_load_data, 0);
    chk("rst_mem_addr", bus.o_mem_addr, 0);
    chk("rst_wdata", bus.o_mem_write_data, 0);

    issue(0, 3'b000, 32'h103, 0, 0);
    wait_idle();
    chk("lb_103", bus.o_load_data, 32'hFFFF_FF80);
    issue(0, 3'b101, 32'h102, 0, 0);
    wait_idle();
    chk("lhu_102", bus.o_load_data, 32'h0000_80FF);
    issue(0, 3'b001, 32'h102, 0, 0);
    wait_idle();
    chk("lh_102", bus.o_load_data, 32'hFFFF_80FF);
    issue(1, 3'b000, 32'h201, 32'h0000_00AB, 0);
    issue(0, 3'b100, 32'h201, 0, 0);
    wait_idle();
    chk("sb_201_readback", bus.o_load_data, 32'h0000_00AB);
    issue(1, 3'b010, 32'h202, 32'h1234_5678, 0);
    issue(0, 3'b010, MB, 0, 0);
    wait_idle();
    chk("fault_keeps_load", bus.o_load_data, 32'h0000_00AB);
    issue(0, 3'b010, 32'h100, 0, 2);
    wait_idle();
    chk("lw_100", bus.o_load_data, 32'h80FF_0102);

    // Reset in LOAD_REQ with i_start held: aborts the load, no o_done.
    wait_idle();
    bus.i_start = 1;
    bus.i_is_store = 0;
    bus.i_funct3 = 3'b010;
    bus.i_addr = 32'h100;
    @(posedge i_Clk);
    #1;
    chk("strobe_in_load_req", 32'(bus.o_read_strobe), 1);
    i_Reset = 1;
    @(posedge i_Clk);
    #1;
    chk("mid_rst_busy", 32'(bus.o_busy), 0);
    chk("mid_rst_done", 32'(bus.o_done), 0);
    chk("mid_rst_strobe", 32'(bus.o_read_strobe), 0);
    chk("mid_rst_mask", 32'(bus.o_mem_write_mask), 0);
    chk("mid_rst_load_data", bus.o_load_data, 0);
    chk("mid_rst_mem_addr", bus.o_mem_addr, 0);
    i_Reset = 0;
    bus.i_start = 0;
    last_load = 0;
    repeat (4) @(posedge i_Clk);
    #1;

    repeat (300) begin
      mode = $urandom_range(0, 9);
      case (mode)
        0: a = MB + $urandom_range(0, 7);
        1: a = 32'hFFFF_FFFC;
        2: a = MB - 1 - $urandom_range(0, 7);
        default: a = $urandom_range(0, 127);
      endcase
      if (mode >= 5) a[1:0] = 2'b00;
      issue(1'($urandom), 3'($urandom), a, $urandom, $urandom_range(0, 3));
    end
    wait_idle();
    repeat (3) @(posedge i_Clk);
    #1;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
